// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed common-anode 7-segment scanner with double-buffered digit data.
// Latency: seg_n/an_n are registered, one cycle behind the prescaler/index state.
// Backpressure: none; load is a fire-and-forget strobe, the last load before a frame boundary wins.
module seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int GUARD      = 16,
  parameter int BLINK_DIV  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start,
  output logic                    blink_phase,
  output logic                    update_pending
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GUARD_END = PW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_DIV - 1);

  // Everything the view logic hands over in one load, kept together so both buffers move as a unit.
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   blink;
    logic [NUM_DIGITS-1:0]   dp;
  } dispBuf_t;

  logic [PW-1:0]         prescaler;
  logic [IW-1:0]         digitIdx;
  logic [FW-1:0]         frameCnt;
  dispBuf_t              inBuf;
  dispBuf_t              pendBuf;
  dispBuf_t              activeBuf;
  logic                  slotEnd;
  logic                  frameWrap;
  logic [3:0]            curDigit;
  logic                  curBlank;
  logic                  curBlink;
  logic                  curDp;
  logic [NUM_DIGITS-1:0] anSel;

  // Segment patterns for 0-F, active low, order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decodeHex(input logic [3:0] val);
    logic [6:0] pat;
    case (val)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

  assign inBuf = '{digits: digits_in, blank: blank_in, blink: blink_in, dp: dp_in};

  assign slotEnd   = (prescaler == PRE_LAST);
  assign frameWrap = slotEnd && (digitIdx == IDX_LAST);

  // Slot timing: prescaler sweeps one digit slot, index steps to the next digit after terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      digitIdx  <= '0;
    end else if (slotEnd) begin
      prescaler <= '0;
      digitIdx  <= frameWrap ? '0 : digitIdx + IW'(1);
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // Frame pulse coincides with the index wrapping to 0; the frame counter paces the blink phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      frameCnt    <= '0;
      blink_phase <= 1'b0;
    end else begin
      frame_start <= frameWrap;
      if (frameWrap) begin
        if (frameCnt == FRM_LAST) begin
          frameCnt    <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frameCnt <= frameCnt + FW'(1);
        end
      end
    end
  end

  // Double buffer: loads land in pending, which is promoted only in the frame_start cycle so a frame
  // never mixes old and new digits. A load in that same cycle goes straight through to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendBuf        <= '0;
      activeBuf      <= '0;
      update_pending <= 1'b0;
    end else if (frame_start) begin
      if (load) begin
        pendBuf        <= inBuf;
        activeBuf      <= inBuf;
        update_pending <= 1'b0;
      end else if (update_pending) begin
        activeBuf      <= pendBuf;
        update_pending <= 1'b0;
      end
    end else if (load) begin
      pendBuf        <= inBuf;
      update_pending <= 1'b1;
    end
  end

  // Pick out the attributes of the digit currently being scanned and its one-hot anode.
  always_comb begin
    curDigit = activeBuf.digits[{digitIdx, 2'b00} +: 4];
    curBlank = activeBuf.blank[digitIdx];
    curBlink = activeBuf.blink[digitIdx];
    curDp    = activeBuf.dp[digitIdx];
    anSel    = '0;
    anSel[digitIdx] = 1'b1;
  end

  // Pin drivers: all dark during the guard window so the previous digit's segments cannot ghost onto
  // the next anode; hidden digits keep their anode slot so the duty cycle of the others is unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= 8'hFF;
      an_n  <= '1;
    end else if (prescaler < GUARD_END) begin
      seg_n <= 8'hFF;
      an_n  <= '1;
    end else begin
      an_n <= ~anSel;
      if (curBlank || (curBlink && blink_phase)) begin
        seg_n <= 8'hFF;
      end else begin
        seg_n <= {~curDp, decodeHex(curDigit)};
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with a short scan (4 digits, 4 cycles per slot, 1 guard cycle, blink every 2 frames).
// A cycle-indexed reference model pushes the expected pin state each clock; a monitor pops and compares it.
// Directed steps cover scan order, decode sweep, double buffering, blink/blank, guard and async reset.
module tb_seg_scan_driver;

  localparam int ND        = 4;
  localparam int SD        = 4;
  localparam int GD        = 1;
  localparam int BD        = 2;
  localparam int FRAME_LEN = ND * SD;

  logic          clk;
  logic          rst_n;
  logic [15:0]   digits_in;
  logic [3:0]    blank_in;
  logic [3:0]    blink_in;
  logic [3:0]    dp_in;
  logic          load;
  logic [7:0]    seg_n;
  logic [3:0]    an_n;
  logic          frame_start;
  logic          blink_phase;
  logic          update_pending;

  int tests = 0;
  int fails = 0;

  logic [7:0] SEG_TAB [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scan_driver #(
    .NUM_DIGITS(ND),
    .SCAN_DIV  (SD),
    .GUARD     (GD),
    .BLINK_DIV (BD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .digits_in     (digits_in),
    .blank_in      (blank_in),
    .blink_in      (blink_in),
    .dp_in         (dp_in),
    .load          (load),
    .seg_n         (seg_n),
    .an_n          (an_n),
    .frame_start   (frame_start),
    .blink_phase   (blink_phase),
    .update_pending(update_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Blink phase in force during cycle c (cycle 0 = first cycle after reset release).
  function automatic int phaseAt(input int c);
    return ((c / FRAME_LEN) / BD) % 2;
  endfunction

  // ---------------- reference model / scoreboard ----------------
  int          cyc;
  logic [15:0] mPendDig, mActDig;
  logic [3:0]  mPendBlank, mActBlank, mPendBlink, mActBlink, mPendDp, mActDp;
  logic        mUpd;
  logic [11:0] expQ [$];
  int          mPre, mIdx;
  logic [7:0]  mSeg;
  logic [3:0]  mAn;
  logic [11:0] expOut;

  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0;
      mPendDig = '0; mActDig = '0;
      mPendBlank = '0; mActBlank = '0;
      mPendBlink = '0; mActBlink = '0;
      mPendDp = '0; mActDp = '0;
      mUpd = 1'b0;
      expQ.delete();
    end else begin
      mPre = cyc % SD;
      mIdx = (cyc / SD) % ND;
      if (mPre < GD) begin
        expOut = {8'hFF, 4'hF};
      end else begin
        mAn = 4'hF;
        mAn[mIdx] = 1'b0;
        mSeg = SEG_TAB[mActDig[mIdx*4 +: 4]];
        if (mActDp[mIdx]) mSeg[7] = 1'b0;
        if (mActBlank[mIdx] || (mActBlink[mIdx] && phaseAt(cyc) == 1)) mSeg = 8'hFF;
        expOut = {mSeg, mAn};
      end
      expQ.push_back(expOut);
      if (cyc > 0 && cyc % FRAME_LEN == 0) begin
        if (load) begin
          mPendDig = digits_in; mPendBlank = blank_in; mPendBlink = blink_in; mPendDp = dp_in;
          mActDig  = digits_in; mActBlank  = blank_in; mActBlink  = blink_in; mActDp  = dp_in;
          mUpd = 1'b0;
        end else if (mUpd) begin
          mActDig = mPendDig; mActBlank = mPendBlank; mActBlink = mPendBlink; mActDp = mPendDp;
          mUpd = 1'b0;
        end
      end else if (load) begin
        mPendDig = digits_in; mPendBlank = blank_in; mPendBlink = blink_in; mPendDp = dp_in;
        mUpd = 1'b1;
      end
      cyc++;
    end
  end

  logic [11:0] popped;
  always @(negedge clk) begin
    if (rst_n) begin
      if (expQ.size() > 0) begin
        popped = expQ.pop_front();
        check("mon_seg", seg_n, popped[11:4]);
        check("mon_an", an_n, popped[3:0]);
      end
      check("mon_frame_start", frame_start, (cyc > 0 && cyc % FRAME_LEN == 0));
      check("mon_blink_phase", blink_phase, phaseAt(cyc));
      check("mon_update_pending", update_pending, mUpd);
      check("mon_one_anode", ($countones(~an_n) <= 1), 1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic doLoad(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk,
                        input logic [3:0] dp);
    digits_in = d; blank_in = bl; blink_in = bk; dp_in = dp;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic waitFs(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 4 * FRAME_LEN);
    check(tag, frame_start, 1);
  endtask

  task automatic waitAn(input string tag, input logic [3:0] pat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an_n !== pat && n < 4 * FRAME_LEN);
    check(tag, an_n, pat);
  endtask

  int         lowCnt [4];
  int         nHid, nShow, nAn3, nRel;
  logic [7:0] expSeg;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; load = 1'b0;
    digits_in = '0; blank_in = '0; blink_in = '0; dp_in = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("reset_seg", seg_n, 8'hFF);
    check("reset_an", an_n, 4'hF);
    check("reset_frame_start", frame_start, 0);
    check("reset_blink", blink_phase, 0);
    check("reset_pending", update_pending, 0);

    // Scan order: load 3210 in cycle 2, watch one full frame after it is applied
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    doLoad(16'h3210, 4'h0, 4'h0, 4'h0);
    check("scan_pending_set", update_pending, 1);
    waitFs("scan_first_fs");
    for (int k = 0; k < 4; k++) lowCnt[k] = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (an_n[k] == 1'b0) begin
          lowCnt[k]++;
          check("scan_digit_seg", seg_n, SEG_TAB[k]);
        end
      end
    end
    for (int k = 0; k < 4; k++) check("scan_low_cycles", lowCnt[k], 3);
    check("scan_fs_period", frame_start, 1);
    @(negedge clk);

    // Decode sweep on digit 0 with its decimal point lit
    for (int v = 0; v < 16; v++) begin
      doLoad(16'(v), 4'h0, 4'h0, 4'b0001);
      waitFs("sweep_fs");
      waitAn("sweep_an", 4'b1110);
      check("decode_dp", seg_n, SEG_TAB[v] & 8'h7F);
    end

    // Double buffer: mid-frame load waits for the boundary
    doLoad(16'hAAAA, 4'h0, 4'h0, 4'h0);
    check("db_pending_set", update_pending, 1);
    waitAn("db_an1_old", 4'b1101);
    check("db_old_value", seg_n, SEG_TAB[0]);
    check("db_pending_hold", update_pending, 1);
    waitFs("db_fs");
    @(negedge clk);
    check("db_pending_clr", update_pending, 0);
    waitAn("db_an1_new", 4'b1101);
    check("db_new_value", seg_n, 8'h88);

    // Load coincident with the boundary goes straight to the display
    doLoad(16'h5555, 4'h0, 4'h0, 4'h0);
    waitFs("coinc_fs_a");
    waitFs("coinc_fs_b");
    doLoad(16'hAAAA, 4'h0, 4'h0, 4'h0);
    check("coinc_pending", update_pending, 0);
    waitAn("coinc_an", 4'b1110);
    check("coinc_value", seg_n, 8'h88);

    // Blink digit 1, blank digit 3
    doLoad(16'h1111, 4'b1000, 4'b0010, 4'b0000);
    waitFs("blink_fs_a");
    waitFs("blink_fs_b");
    @(negedge clk);
    check("guard_an", an_n, 4'hF);
    check("guard_seg", seg_n, 8'hFF);
    nHid = 0; nShow = 0; nAn3 = 0;
    for (int i = 0; i < 4 * FRAME_LEN; i++) begin
      @(negedge clk);
      if (an_n == 4'b1101) begin
        expSeg = (phaseAt(cyc - 1) == 1) ? 8'hFF : SEG_TAB[1];
        check("blink_d1", seg_n, expSeg);
        if (expSeg == 8'hFF) nHid++;
        else nShow++;
      end
      if (an_n == 4'b0111) begin
        nAn3++;
        check("blank_d3", seg_n, 8'hFF);
      end
    end
    check("blink_hidden_seen", (nHid > 0), 1);
    check("blink_shown_seen", (nShow > 0), 1);
    check("blank_an3_driven", (nAn3 > 0), 1);

    // Async reset mid-slot with a pending update
    waitAn("rst_an0", 4'b1110);
    doLoad(16'h1234, 4'h0, 4'h0, 4'h0);
    check("rst_pending_before", update_pending, 1);
    check("rst_lit_before", an_n, 4'b1110);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_seg", seg_n, 8'hFF);
    check("rst_async_an", an_n, 4'hF);
    check("rst_async_pending", update_pending, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rel_pending", update_pending, 0);
    check("rel_blink", blink_phase, 0);
    nRel = 0;
    do begin
      @(negedge clk);
      nRel++;
    end while (!frame_start && nRel < 4 * FRAME_LEN);
    check("rel_first_fs_cycles", nRel, FRAME_LEN);
    waitAn("rel_an0", 4'b1110);
    check("rel_load_discarded", seg_n, SEG_TAB[0]);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
